// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: hex glyph table (active-high g..a), blank
// pattern and the capture FSM state type.
package seven_seg_pkg;

  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    IDLE    = 1'b0,
    GOT_LSB = 1'b1
  } state_e;

endpackage

// File: rtl/seven_seg_unhex.sv
// Combinational glyph decoder: active-high segment pattern -> {hit, nibble}.
module seven_seg_unhex
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       hit,
  output logic [3:0] nibble
);

  always_comb begin
    hit    = 1'b0;
    nibble = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (pattern == SEG_HEX[i]) begin
        hit    = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Receiver for the multiplexed two-digit seven-segment bus: debounces each
// digit, decodes it and reassembles the displayed byte {msb, lsb}.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] seg_in,
  output logic [7:0] dout,
  output logic       valid,
  output logic       err,
  output logic       timeout
);

  localparam int unsigned RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [7:0]       seg_q, seg_d;
  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic             accept_q, accept_d;
  state_e           state_q, state_d;
  logic [3:0]       lsb_q, lsb_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             timeout_q, timeout_d;

  logic [6:0] pattern;
  logic       hit;
  logic [3:0] nibble;

  assign pattern = ~seg_q[6:0];

  seven_seg_unhex u_unhex (
    .pattern (pattern),
    .hit     (hit),
    .nibble  (nibble)
  );

  // run_len_d is the age of seg_q after this edge; accept is registered so the
  // FSM decodes seg_q, which is guaranteed still to hold the accepted value.
  always_comb begin
    seg_d = seg_in;
    if (seg_in != seg_q)       run_len_d = RUN_W'(1);
    else if (run_len_q != RUN_MAX) run_len_d = run_len_q + RUN_W'(1);
    else                       run_len_d = run_len_q;
    accept_d = (run_len_d == RUN_MAX) && (run_len_q != RUN_MAX);
  end

  always_comb begin
    state_d   = state_q;
    lsb_d     = lsb_q;
    tmo_d     = '0;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept_q && pattern != SEG_BLANK) begin
          if (!hit) begin
            err_d = 1'b1;
          end else if (seg_q[7]) begin
            lsb_d   = nibble;
            state_d = GOT_LSB;
          end
        end
      end
      GOT_LSB: begin
        // a blank accept is a non-event, so it neither resets nor masks the timeout
        if (accept_q && pattern != SEG_BLANK) begin
          if (!hit) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (seg_q[7]) begin
            lsb_d = nibble;
          end else begin
            dout_d  = {nibble, lsb_q};
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end else if (tmo_q == TMO_MAX) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      seg_q     <= '0;
      run_len_q <= '0;
      accept_q  <= 1'b0;
      state_q   <= IDLE;
      lsb_q     <= '0;
      tmo_q     <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      seg_q     <= seg_d;
      run_len_q <= run_len_d;
      accept_q  <= accept_d;
      state_q   <= state_d;
      lsb_q     <= lsb_d;
      tmo_q     <= tmo_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign dout    = dout_q;
  assign valid   = valid_q;
  assign err     = err_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture: directed scenarios with literal
// expectations, then randomized bus traffic against a behavioural model.
module tb_seven_seg_capture;

  localparam int S = 4;
  localparam int T = 64;

  localparam logic [6:0] GLY [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic       CLK = 1'b0;
  logic       reset;
  logic [7:0] seg_in;
  logic [7:0] dout;
  logic       valid, err, timeout;

  int n_cmp = 0;
  int n_bad = 0;

  seven_seg_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .CLK     (CLK),
    .reset   (reset),
    .seg_in  (seg_in),
    .dout    (dout),
    .valid   (valid),
    .err     (err),
    .timeout (timeout)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 25) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int glyph_idx(input logic [6:0] p);
    glyph_idx = -1;
    for (int i = 0; i < 16; i++) if (GLY[i] == p) glyph_idx = i;
  endfunction

  // Behavioural model: a digit is accepted when its sample run first reaches S;
  // the decision becomes visible one edge later.
  bit         m_live = 0, m_valid = 0, m_err = 0, m_tmo = 0;
  logic [7:0] m_dout = '0;
  int         age = 0, cyc = 0, entry = 0, idx = 0;
  bit         pend = 0, have_lsb = 0, acted = 0;
  logic [7:0] last = '0, pend_val = '0;
  logic [6:0] p;
  logic [3:0] lsb = '0;

  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
      m_valid = 0; m_err = 0; m_tmo = 0;
      if (reset) begin
        m_live = 1; age = 0; pend = 0; have_lsb = 0; m_dout = '0;
      end else begin
        acted = 0;
        p = ~pend_val[6:0];
        if (pend && p != 7'h00) begin
          acted = 1;
          idx = glyph_idx(p);
          if (idx < 0) begin
            m_err = 1; have_lsb = 0;
          end else if (pend_val[7]) begin
            have_lsb = 1; lsb = idx[3:0]; entry = cyc;
          end else if (have_lsb) begin
            m_dout = {idx[3:0], lsb}; m_valid = 1; have_lsb = 0;
          end
        end
        if (!acted && have_lsb && (cyc - entry) == T) begin
          m_tmo = 1; have_lsb = 0;
        end
        age = (age == 0 || seg_in != last) ? 1 : age + 1;
        last = seg_in;
        pend = (age == S);
        pend_val = seg_in;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (m_live) begin
        check("cyc_dout", 32'(dout), 32'(m_dout));
        check("cyc_valid", 32'(valid), 32'(m_valid));
        check("cyc_err", 32'(err), 32'(m_err));
        check("cyc_timeout", 32'(timeout), 32'(m_tmo));
      end
    end
  end

  int nv, ne, nt, ngood, fv, ft;
  logic [7:0] last_d;

  task automatic clr();
    nv = 0; ne = 0; nt = 0; ngood = 0; last_d = '0;
  endtask

  task automatic step(input int n);
    fv = 0; ft = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge CLK);
      if (valid === 1'b1) begin
        nv++; last_d = dout;
        if (fv == 0) fv = i;
        if (dout === 8'h3A) ngood++;
      end
      if (err === 1'b1) ne++;
      if (timeout === 1'b1) begin
        nt++;
        if (ft == 0) ft = i;
      end
    end
  endtask

  function automatic logic [7:0] pick();
    int r;
    int g;
    r = $urandom_range(0, 9);
    g = $urandom_range(0, 15);
    case (r)
      0, 1, 2: pick = {1'b1, ~GLY[g]};
      3, 4, 5: pick = {1'b0, ~GLY[g]};
      6:       pick = {1'($urandom_range(0, 1)), 7'h7F};
      7:       pick = {1'($urandom_range(0, 1)), 7'h3F};
      8:       pick = 8'($urandom);
      default: pick = ($urandom_range(0, 1) == 1) ? 8'h88 : 8'h30;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    seg_in = 8'hFF;
    clr();
    step(3);
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_timeout", 32'(timeout), 32'h0);
    reset = 1'b0;
    step(8);

    clr();
    seg_in = 8'h88; step(8);
    seg_in = 8'h30; step(8);
    check("t1_valid_count", 32'(nv), 32'd1);
    check("t1_latency", 32'(fv), 32'd5);
    check("t1_dout", 32'(last_d), 32'h3A);
    check("t1_model_dout", 32'(m_dout), 32'h3A);

    clr();
    seg_in = 8'h88; step(3);
    seg_in = 8'h30; step(8);
    check("t2_valid_count", 32'(nv), 32'd0);

    clr();
    seg_in = 8'hBF; step(8);
    check("t3_err_count", 32'(ne), 32'd1);
    check("t3_valid_count", 32'(nv), 32'd0);
    check("t3_dout_held", 32'(dout), 32'h3A);

    clr();
    seg_in = 8'h88; step(8);
    seg_in = 8'hFF; step(80);
    check("t4_timeout_count", 32'(nt), 32'd1);
    check("t4_timeout_cycle", 32'(ft), 32'd61);
    check("t4_valid_count", 32'(nv), 32'd0);

    clr();
    seg_in = 8'h88; step(8);
    reset = 1'b1; step(1);
    check("t5_reset_dout", 32'(dout), 32'h0);
    check("t5_reset_pulses", 32'({valid, err, timeout}), 32'h0);
    reset = 1'b0;
    seg_in = 8'h30; step(8);
    check("t5_valid_count", 32'(nv), 32'd0);

    clr();
    for (int i = 0; i < 10; i++) begin
      seg_in = 8'h88; step(16);
      seg_in = 8'h30; step(16);
    end
    check("t6_valid_count", 32'(nv), 32'd10);
    check("t6_dout_3a_count", 32'(ngood), 32'd10);
    check("t6_model_dout", 32'(m_dout), 32'h3A);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1; step(1); reset = 1'b0;
      end
      seg_in = pick();
      step(($urandom_range(0, 15) == 0) ? 70 : int'($urandom_range(1, 12)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
